// File: rtl/lcd_time_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : lcd_time_sequencer
// Purpose  : Drives an HD44780-class text LCD in 8-bit write-only mode.
//            After reset it waits for LCD power-up and sends the init
//            commands 0x38, 0x0C, 0x06 and 0x01. On each update request it
//            rewrites the first 8 cells of line 1 from eight 4-bit codes.
//            Each code is converted to ASCII by an external combinational
//            decoder: the code goes out on o_num_out and the ASCII byte
//            comes back on i_dec_in.
// Ports    : clk, rst_n        - clock, asynchronous active-low reset
//            i_codes[31:0]     - cell k code at [4k+3:4k], k=0 leftmost
//            i_update          - one-cycle refresh request
//            i_dec_in[7:0]     - ASCII byte returned by the decoder
//            o_num_out[3:0]    - code presented to the decoder
//            o_lcd_e/rs/rw     - LCD strobe, register select, read/write (0)
//            o_lcd_data[7:0]   - LCD data bus
//            o_busy            - init or refresh frame in progress
//            o_init_done       - init sequence has completed
// Revision : 1.0 - initial release
// ============================================================================
module lcd_time_sequencer #(
  parameter int PWR_CYCLES = 15000,
  parameter int E_CYCLES   = 2,
  parameter int CMD_CYCLES = 40,
  parameter int CLR_CYCLES = 1640
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] i_codes,
  input  logic        i_update,
  input  logic [7:0]  i_dec_in,
  output logic [3:0]  o_num_out,
  output logic        o_lcd_e,
  output logic        o_lcd_rs,
  output logic        o_lcd_rw,
  output logic [7:0]  o_lcd_data,
  output logic        o_busy,
  output logic        o_init_done
);

  // One shared down-time counter, sized for the longest interval
  localparam int c_max_a = (PWR_CYCLES > CLR_CYCLES) ? PWR_CYCLES : CLR_CYCLES;
  localparam int c_max_b = (CMD_CYCLES > E_CYCLES) ? CMD_CYCLES : E_CYCLES;
  localparam int c_max   = (c_max_a > c_max_b) ? c_max_a : c_max_b;
  localparam int c_cw    = $clog2(c_max + 1);

  localparam logic [c_cw-1:0] c_pwr_last = c_cw'(PWR_CYCLES - 1);
  localparam logic [c_cw-1:0] c_e_last   = c_cw'(E_CYCLES - 1);
  localparam logic [c_cw-1:0] c_cmd_last = c_cw'(CMD_CYCLES - 1);
  localparam logic [c_cw-1:0] c_clr_last = c_cw'(CLR_CYCLES - 1);
  localparam logic [c_cw-1:0] c_cnt_zero = '0;
  localparam logic [c_cw-1:0] c_cnt_one  = c_cw'(1);

  typedef enum logic [2:0] {
    S_PWR    = 3'd0,
    S_SETUP  = 3'd1,
    S_STROBE = 3'd2,
    S_WAIT   = 3'd3,
    S_PREP   = 3'd4,
    S_IDLE   = 3'd5
  } state_t;

  state_t            r_state;
  logic [c_cw-1:0]   r_cnt;
  logic [c_cw-1:0]   r_wait_last;
  // Byte index in the current sequence: init 0..3, frame 0 (address) .. 8
  logic [3:0]        r_step;
  logic              r_in_init;
  logic              r_pending;
  logic [31:0]       r_snap;
  logic [3:0]        r_num;
  logic              r_e;
  logic              r_rs;
  logic [7:0]        r_data;
  logic              r_busy;
  logic              r_done;

  logic [3:0]        w_next_step;
  logic              w_seq_end;
  logic              w_start_frame;

  function automatic logic [7:0] f_init_cmd(input logic [1:0] idx);
    case (idx)
      2'd0:    return 8'h38;  // 8-bit bus, 2 lines, 5x8 font
      2'd1:    return 8'h0C;  // display on, cursor off
      2'd2:    return 8'h06;  // increment, no shift
      default: return 8'h01;  // clear display
    endcase
  endfunction

  assign w_next_step = r_step + 4'd1;

  // Last byte of the init sequence or of a frame has finished its wait
  assign w_seq_end = (r_state == S_WAIT) && (r_cnt == r_wait_last) &&
                     (r_in_init ? (r_step == 4'd3) : (r_step == 4'd8));

  // A frame starts from IDLE, or back-to-back when a request is waiting
  // (or arrives) exactly as the previous sequence ends.
  assign w_start_frame = ((r_state == S_IDLE) && i_update) ||
                         (w_seq_end && (r_pending || i_update));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_PWR;
      r_cnt       <= c_cnt_zero;
      r_wait_last <= c_cnt_zero;
      r_step      <= 4'd0;
      r_in_init   <= 1'b0;
      r_pending   <= 1'b0;
      r_snap      <= 32'd0;
      r_num       <= 4'd0;
      r_e         <= 1'b0;
      r_rs        <= 1'b0;
      r_data      <= 8'h00;
      r_busy      <= 1'b1;
      r_done      <= 1'b0;
    end else begin
      if (i_update && (r_state != S_IDLE)) begin
        r_pending <= 1'b1;
      end

      case (r_state)
        S_PWR: begin
          if (r_cnt == c_pwr_last) begin
            r_cnt     <= c_cnt_zero;
            r_step    <= 4'd0;
            r_in_init <= 1'b1;
            r_rs      <= 1'b0;
            r_data    <= f_init_cmd(2'd0);
            r_state   <= S_SETUP;
          end else begin
            r_cnt <= r_cnt + c_cnt_one;
          end
        end

        S_SETUP: begin
          r_e         <= 1'b1;
          r_cnt       <= c_cnt_zero;
          // The clear command needs the long post-write wait
          r_wait_last <= (!r_rs && (r_data == 8'h01)) ? c_clr_last : c_cmd_last;
          r_state     <= S_STROBE;
        end

        S_STROBE: begin
          if (r_cnt == c_e_last) begin
            r_e     <= 1'b0;
            r_cnt   <= c_cnt_zero;
            r_state <= S_WAIT;
          end else begin
            r_cnt <= r_cnt + c_cnt_one;
          end
        end

        S_WAIT: begin
          if (r_cnt != r_wait_last) begin
            r_cnt <= r_cnt + c_cnt_one;
          end else if (r_in_init && (r_step != 4'd3)) begin
            r_cnt   <= c_cnt_zero;
            r_step  <= w_next_step;
            r_data  <= f_init_cmd(w_next_step[1:0]);
            r_state <= S_SETUP;
          end else if (!r_in_init && (r_step != 4'd8)) begin
            // r_step (0..7) is the index of the next cell to write
            r_cnt   <= c_cnt_zero;
            r_step  <= w_next_step;
            r_num   <= r_snap[{r_step[2:0], 2'b00} +: 4];
            r_state <= S_PREP;
          end else begin
            if (r_in_init) begin
              r_done <= 1'b1;
            end
            r_in_init <= 1'b0;
            r_busy    <= 1'b0;
            r_state   <= S_IDLE;
          end
        end

        S_PREP: begin
          // Decoder has had one full clock to settle on r_num
          r_data  <= i_dec_in;
          r_rs    <= 1'b1;
          r_state <= S_SETUP;
        end

        S_IDLE: begin
        end

        default: begin
          r_state <= S_PWR;
        end
      endcase

      // Frame start overrides the sequence-end assignments above
      if (w_start_frame) begin
        r_snap    <= i_codes;
        r_pending <= 1'b0;
        r_busy    <= 1'b1;
        r_in_init <= 1'b0;
        r_step    <= 4'd0;
        r_cnt     <= c_cnt_zero;
        r_rs      <= 1'b0;
        r_data    <= 8'h80;
        r_state   <= S_SETUP;
      end
    end
  end

  assign o_num_out   = r_num;
  assign o_lcd_e     = r_e;
  assign o_lcd_rs    = r_rs;
  assign o_lcd_rw    = 1'b0;  // write-only interface
  assign o_lcd_data  = r_data;
  assign o_busy      = r_busy;
  assign o_init_done = r_done;

endmodule
`default_nettype wire
